// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - Bit-serial WIDTH-bit subtractor, LSB first; optional ovf via SERIAL_SUB_OVF_EN

// Single-bit full subtractor: dif = a - b - bin, bout = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic dif,
    output logic bout
);

    // Pure combinational cell; the caller owns the borrow register.
    assign dif  = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic load;
    logic shift_en;
    logic last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Upper WIDTH-1 result bits; the newest bit comes straight from the cell.
    logic [WIDTH-2:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             cell_dif;
    logic             cell_bout;
    logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    full_sub u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .dif  (cell_dif),
        .bout (cell_bout)
    );

    // On the final shift this is the complete result, LSB landing in bit 0.
    assign res_nxt = {cell_dif, res_sh};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; start is only looked at while idle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flip-flop, partial result and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (shift_en) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt[WIDTH-1:1];
            borrow <= cell_bout;
            // Hold on the last bit so the counter never wraps inside an operation.
            cnt    <= last ? cnt : cnt + CW'(1);
        end
    end

    // Busy flag and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                busy <= 1'b1;
            end else if (last) begin
                busy <= 1'b0;
            end
        end
    end

    // Result registers: updated only on completion, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last) begin
            diff <= res_nxt;
            bout <= cell_bout;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Sign bits of the accepted operands, kept for the overflow decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from a.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= (a_msb ^ b_msb) & (a_msb ^ cell_dif);
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - Self-checking bench for serial_sub (WIDTH=8 and WIDTH=4 instances)

module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8;
    logic       ovf4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    // Reference model: plain integer arithmetic on unsigned/signed values.
    function automatic int ref_diff(input int x, input int y, input int w);
        int m;
        m = 1 << w;
        return ((x - y) % m + m) % m;
    endfunction

    function automatic int ref_bout(input int x, input int y);
        return (x < y) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int x, input int y, input int w);
        int sx;
        int sy;
        int sd;
        sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
        sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
        sd = sx - sy;
        return (sd > (1 << (w - 1)) - 1 || sd < -(1 << (w - 1))) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 op; returns in the done cycle with the edge count.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, output int lat);
        start8 = 1'b1;
        a8     = x;
        b8     = y;
        tick();
        start8 = 1'b0;
        lat    = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, output int lat);
        start4 = 1'b1;
        a4     = x;
        b4     = y;
        tick();
        start4 = 1'b0;
        lat    = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y);
        int lat;
        run8(x, y, lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_diff"}, diff8, ref_diff(x, y, 8));
        check({tag, "_bout"}, bout8, ref_bout(x, y));
        check({tag, "_busy"}, busy8, 0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf8, ref_ovf(x, y, 8));
`endif
    endtask

    initial begin
        int lat;
        int pulses;
        logic [7:0] seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        tick();
        tick();
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_bout", bout8, 0);
        check("rst_busy4", busy4, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf8, 0);
`endif
        rst = 1'b0;
        tick();

        // Directed vectors
        op8("d05_03", 8'h05, 8'h03);
        tick();
        check("pulse_clear", done8, 0);
        check("diff_hold", diff8, 8'h02);
        op8("d03_05", 8'h03, 8'h05);
        op8("d00_01", 8'h00, 8'h01);
        op8("dA5_A5", 8'hA5, 8'hA5);
        op8("dFF_00", 8'hFF, 8'h00);

        // Start accepted in the done cycle; diff not cleared on start
        start8 = 1'b1;
        a8     = 8'h33;
        b8     = 8'h11;
        tick();
        start8 = 1'b0;
        check("b2b_busy", busy8, 1);
        check("b2b_noclear", diff8, 8'hFF);
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_lat", lat, 8);
        check("b2b_diff", diff8, 8'h22);

        // Start while busy is ignored; operand changes mid-shift ignored
        tick();
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h01;
        tick();
        a8 = 8'hFF;
        b8 = 8'h00;
        tick();
        tick();
        tick();
        start8 = 1'b0;
        a8     = 8'h77;
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 14; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                seen = diff8;
            end
            tick();
        end
        check("busy_ign_pulses", pulses, 1);
        check("busy_ign_diff", seen, 8'h0F);

        // Reset during SHIFT
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h22;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_diff", diff8, 0);
        check("midrst_bout", bout8, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) pulses++;
            tick();
        end
        check("midrst_nodone", pulses, 0);
        op8("post_rst", 8'h03, 8'h05);

`ifdef SERIAL_SUB_OVF_EN
        op8("ovf80_01", 8'h80, 8'h01);
        check("ovf80_01_direct", ovf8, 1);
        op8("ovf10_01", 8'h10, 8'h01);
        check("ovf10_01_direct", ovf8, 0);
`endif

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 8 == 0) rb = ra;
            op8("rand", ra, rb);
        end

        // Exhaustive WIDTH=4 sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y), lat);
                check("sw4_lat", lat, 4);
                check("sw4_diff", diff4, ref_diff(x, y, 4));
                check("sw4_bout", bout4, ref_bout(x, y));
`ifdef SERIAL_SUB_OVF_EN
                check("sw4_ovf", ovf4, ref_ovf(x, y, 4));
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
